// File: rtl/hilo_div_unit_if.sv
// HI/LO + divider bus bundle between the ALU stage and hilo_div_unit.
// Master drives the op; slave returns busy, hi/lo and the divide-by-zero pulse.
interface hilo_div_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [2:0]           hiloOp;
    logic [2*WIDTH-1:0]   aluResult;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 flush;
    logic                 busy;
    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;
    logic                 divByZero;

    modport master (
        output start, hiloOp, aluResult, A, B, flush,
        input  busy, hi, lo, divByZero
    );

    modport slave (
        input  start, hiloOp, aluResult, A, B, flush,
        output busy, hi, lo, divByZero
    );
endinterface

// File: rtl/hilo_div_unit.sv
// HI/LO register file with a 32-iteration restoring divider (DIV/DIVU).
// Optional macro HILO_BYPASS_EN forwards MULT/MTHI/MTLO writes to hi/lo.
module hilo_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hilo_div_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_MTHI = 3'd2;
    localparam logic [2:0] OP_MTLO = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_DIVU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_FIXUP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  dvd_q, dvd_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              dbz_q, dbz_d;

    logic              accept;
    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    rem_sh;
    logic              fits;

    assign accept = bus.start && (state_q == S_IDLE) && !bus.flush;
    assign a_neg  = (bus.hiloOp == OP_DIV) && bus.A[WIDTH-1];
    assign b_neg  = (bus.hiloOp == OP_DIV) && bus.B[WIDTH-1];
    assign a_mag  = a_neg ? -bus.A : bus.A;
    assign b_mag  = b_neg ? -bus.B : bus.B;

    // Partial remainder shifted left with the next dividend bit brought in
    assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
    assign fits   = rem_sh >= {1'b0, dvs_q};

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state: op accept, one restoring step per cycle, sign fixup
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dbz_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (bus.hiloOp)
                        OP_MULT: {hi_d, lo_d} = bus.aluResult;
                        OP_MTHI: hi_d = bus.A;
                        OP_MTLO: lo_d = bus.A;
                        OP_DIV, OP_DIVU: begin
                            if (bus.B == '0) begin
                                dbz_d = 1'b1;
                            end else begin
                                dvd_d   = a_mag;
                                dvs_d   = b_mag;
                                rem_d   = '0;
                                cnt_d   = '0;
                                qneg_d  = a_neg ^ b_neg;
                                rneg_d  = a_neg;
                                state_d = S_DIVIDE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_DIVIDE: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = fits ? (rem_sh[WIDTH-1:0] - dvs_q)
                                 : rem_sh[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], fits};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    lo_d = qneg_q ? -dvd_q : dvd_q;
                    hi_d = rneg_q ? -rem_q : rem_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.divByZero = dbz_q;

`ifdef HILO_BYPASS_EN
    // Only an idle accept can write in the same cycle, so FIXUP is never forwarded
    assign bus.hi = accept ? hi_d : hi_q;
    assign bus.lo = accept ? lo_d : lo_q;
`else
    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
`endif

endmodule
